// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// default NOP word and the PC increment helper.
package if_fetch_stage_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DROP = 3'd3,
        S_HOLD = 3'd4
    } fetch_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;

    // Sequential PC, wraps modulo 2^32
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register. Priority: flush > load > stall (hold) > drain.
// The instruction field is forced to the NOP word whenever the slot is empty,
// so downstream decode sees a harmless instruction without checking valid.
module if_fetch_stage_ifid_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_load,
    input  logic        i_stall,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;

    // Slot update; pc4 is left untouched on flush/drain since it is meaningless when invalid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end else if (!i_stall) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM with one outstanding
// instruction-memory request, a one-word hold buffer for responses that
// arrive while decode is stalled, and the IF/ID register.
//
// state  | meaning
// S_IDLE | first cycle out of reset, no request
// S_REQ  | request for pc presented, waiting for grant
// S_WAIT | granted, waiting for read data
// S_DROP | in-flight response is stale after a redirect, discard it
// S_HOLD | response captured in hold reg, waiting for decode to unstall
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_next_pc_in,
    input  logic        i_redirect,
    input  logic        i_stall,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_ifid_valid,
    output logic [31:0] o_ifid_instr,
    output logic [31:0] o_ifid_pc4
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_hold;

    logic         w_ifid_valid;
    logic         w_accept;
    logic         w_load_mem;
    logic         w_load_hold;
    logic         w_load;
    logic [31:0]  w_load_instr;
    logic [31:0]  w_pc_plus4;

    assign w_pc_plus4   = pc_inc(r_pc);
    assign w_accept     = !w_ifid_valid || !i_stall;
    assign w_load_mem   = (r_state == S_WAIT) && i_imem_rvalid && !i_redirect && w_accept;
    assign w_load_hold  = (r_state == S_HOLD) && !i_redirect && !i_stall;
    assign w_load       = w_load_mem || w_load_hold;
    assign w_load_instr = w_load_hold ? r_hold : i_imem_rdata;

    // Fetch FSM, PC and hold register; pc only moves on load or redirect so it
    // always names the outstanding fetch
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_hold  <= NOP_INSTR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (i_redirect) begin
                        r_pc <= i_next_pc_in;
                    end
                    if (i_imem_gnt) begin
                        r_state <= i_redirect ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_redirect) begin
                        r_pc    <= i_next_pc_in;
                        r_state <= i_imem_rvalid ? S_REQ : S_DROP;
                    end else if (i_imem_rvalid) begin
                        if (w_accept) begin
                            r_pc    <= i_next_pc_in;
                            r_state <= S_REQ;
                        end else begin
                            r_hold  <= i_imem_rdata;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_DROP: begin
                    if (i_redirect) begin
                        r_pc <= i_next_pc_in;
                    end
                    if (i_imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (i_redirect || !i_stall) begin
                        r_pc    <= i_next_pc_in;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    if_fetch_stage_ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_redirect),
        .i_load  (w_load),
        .i_stall (i_stall),
        .i_instr (w_load_instr),
        .i_pc4   (w_pc_plus4),
        .o_valid (w_ifid_valid),
        .o_instr (o_ifid_instr),
        .o_pc4   (o_ifid_pc4)
    );

    assign o_pc         = r_pc;
    assign o_pc_plus4   = w_pc_plus4;
    assign o_imem_req   = (r_state == S_REQ);
    assign o_imem_addr  = r_pc;
    assign o_ifid_valid = w_ifid_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a small instruction-memory model grants requests and
// returns word = addr ^ 32'hC000_0000 after a programmable latency. Expected
// request addresses and IF/ID contents are queued by the stimulus; the memory
// model and an IF/ID monitor pop and compare independently.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    logic        clk;
    logic        i_rst;
    logic [31:0] i_next_pc_in;
    logic        i_redirect;
    logic        i_stall;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_ifid_valid;
    logic [31:0] o_ifid_instr;
    logic [31:0] o_ifid_pc4;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_next_pc_in  (i_next_pc_in),
        .i_redirect    (i_redirect),
        .i_stall       (i_stall),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_ifid_valid  (o_ifid_valid),
        .o_ifid_instr  (o_ifid_instr),
        .o_ifid_pc4    (o_ifid_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ifid_t       exp_ifid[$];
    logic [31:0] exp_addr[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    // stimulus knobs, applied at the next tick
    logic        rst_v   = 1'b1;
    logic        gnt_en  = 1'b0;
    int          lat     = 1;
    logic        stall_v = 1'b0;
    logic        redir_v = 1'b0;
    logic [31:0] tgt_v   = 32'h0;
    logic        mon_en  = 1'b0;

    // memory model state
    logic        pend  = 1'b0;
    int          pcnt  = 0;
    logic [31:0] paddr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_a(input logic [31:0] a);
        exp_addr.push_back(a);
    endtask

    task automatic push_i(input logic [31:0] instr, input logic [31:0] pc4);
        ifid_t e;
        e.instr = instr;
        e.pc4   = pc4;
        exp_ifid.push_back(e);
    endtask

    // One cycle: at the falling edge, run the memory model and drive all inputs
    task automatic tick();
        logic        rv;
        logic [31:0] rd;
        logic        g;
        @(negedge clk);
        rv = 1'b0;
        rd = 32'h0;
        if (rst_v) begin
            pend = 1'b0;
        end else if (pend) begin
            if (pcnt == 1) begin
                rv   = 1'b1;
                rd   = paddr ^ 32'hC000_0000;
                pend = 1'b0;
            end else begin
                pcnt--;
            end
        end
        g = !rst_v && gnt_en && (o_imem_req === 1'b1);
        if (g) begin
            if (exp_addr.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL imem_addr: unexpected request at %h, none expected", o_imem_addr);
            end else begin
                chk("imem_addr", o_imem_addr, exp_addr.pop_front());
            end
            pend  = 1'b1;
            pcnt  = lat;
            paddr = o_imem_addr;
        end
        i_rst         = rst_v;
        i_stall       = stall_v;
        i_redirect    = redir_v;
        i_next_pc_in  = redir_v ? tgt_v : o_pc_plus4;
        i_imem_gnt    = g;
        i_imem_rvalid = rv;
        i_imem_rdata  = rd;
    endtask

    // IF/ID monitor: an instruction leaves the slot when valid and either not stalled or flushed
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (o_ifid_valid === 1'b1) begin
                    if (!i_stall || i_redirect) begin
                        if (exp_ifid.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL ifid: unexpected instr %h pc4 %h", o_ifid_instr, o_ifid_pc4);
                        end else begin
                            ifid_t e;
                            e = exp_ifid.pop_front();
                            chk("ifid_instr", o_ifid_instr, e.instr);
                            chk("ifid_pc4", o_ifid_pc4, e.pc4);
                        end
                    end
                end else begin
                    chk("ifid_nop", o_ifid_instr, NOP);
                end
            end
        end
    end

    initial begin
        i_rst         = 1'b1;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_next_pc_in  = 32'h0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;

        // reset for two cycles
        tick();
        tick();
        mon_en = 1'b1;
        rst_v  = 1'b0;
        gnt_en = 1'b1;
        lat    = 1;

        // 1: sequential fetch 0,4,8
        push_a(32'h0); push_a(32'h4); push_a(32'h8);
        push_i(32'hC000_0000, 32'h4);
        push_i(32'hC000_0004, 32'h8);
        push_i(32'hC000_0008, 32'hC);
        tick();
        chk("rst_req", {31'd0, o_imem_req}, 32'd0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_valid", {31'd0, o_ifid_valid}, 32'd0);
        chk("rst_instr", o_ifid_instr, NOP);
        chk("rst_pc4", o_ifid_pc4, 32'h0);
        chk("rst_pc_plus4", o_pc_plus4, 32'h4);
        repeat (6) tick();

        // 2: stall three cycles while the next response lands in the hold reg
        push_a(32'hC);
        push_i(32'hC000_000C, 32'h10);
        stall_v = 1'b1;
        tick();
        tick();
        tick();
        chk("hold_req", {31'd0, o_imem_req}, 32'd0);
        chk("hold_valid", {31'd0, o_ifid_valid}, 32'd1);
        chk("hold_instr", o_ifid_instr, 32'hC000_0008);
        chk("hold_pc4", o_ifid_pc4, 32'hC);
        stall_v = 1'b0;
        tick();
        push_a(32'h10);
        lat = 3;
        tick();
        chk("post_hold_req", {31'd0, o_imem_req}, 32'd1);
        chk("post_hold_addr", o_imem_addr, 32'h10);

        // 3: redirect to 0x40 while waiting; stale data must be dropped
        redir_v = 1'b1;
        tgt_v   = 32'h40;
        tick();
        redir_v = 1'b0;
        tick();
        chk("drop_req", {31'd0, o_imem_req}, 32'd0);
        tick();
        lat = 1;
        push_a(32'h40);
        tick();
        chk("redir_addr", o_imem_addr, 32'h40);
        chk("redir_valid", {31'd0, o_ifid_valid}, 32'd0);

        // 4: redirect coincident with rvalid in S_WAIT
        redir_v = 1'b1;
        tgt_v   = 32'h80;
        tick();
        redir_v = 1'b0;
        push_a(32'h80);
        push_i(32'hC000_0080, 32'h84);
        tick();
        chk("coinc_pc", o_pc, 32'h80);
        chk("coinc_valid", {31'd0, o_ifid_valid}, 32'd0);
        tick();

        // 5: redirect while stalled with a valid slot flushes it
        push_a(32'h84);
        stall_v = 1'b1;
        redir_v = 1'b1;
        tgt_v   = 32'h100;
        tick();
        stall_v = 1'b0;
        redir_v = 1'b0;
        tick();
        chk("flush_valid", {31'd0, o_ifid_valid}, 32'd0);
        chk("flush_instr", o_ifid_instr, NOP);

        // 6: PC wrap and reset mid-transaction
        gnt_en  = 1'b0;
        redir_v = 1'b1;
        tgt_v   = 32'hFFFF_FFFC;
        tick();
        chk("nogrant_addr", o_imem_addr, 32'h100);
        redir_v = 1'b0;
        gnt_en  = 1'b1;
        push_a(32'hFFFF_FFFC);
        push_i(32'h3FFF_FFFC, 32'h0);
        tick();
        chk("wrap_pc_plus4", o_pc_plus4, 32'h0);
        chk("wrap_addr", o_imem_addr, 32'hFFFF_FFFC);
        tick();
        push_a(32'h0);
        push_i(32'hC000_0000, 32'h4);
        tick();
        chk("wrap_next_addr", o_imem_addr, 32'h0);
        tick();
        lat = 3;
        push_a(32'h4);
        tick();
        chk("pre_rst_addr", o_imem_addr, 32'h4);
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        tick();
        chk("mid_rst_pc", o_pc, 32'h0);
        chk("mid_rst_req", {31'd0, o_imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, o_ifid_valid}, 32'd0);
        gnt_en = 1'b0;
        tick();
        chk("restart_req", {31'd0, o_imem_req}, 32'd1);
        chk("restart_addr", o_imem_addr, 32'h0);
        tick();
        tick();
        #3;
        chk("ifid_queue_left", exp_ifid.size(), 32'd0);
        chk("addr_queue_left", exp_addr.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
